// File: rtl/muldiv_pkg.sv
// Shared opcodes, FSM encodings and counter sizing for the sequential multiply/divide unit.
package muldiv_pkg;

   localparam int DEF_WIDTH = 16;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Counter must hold WIDTH-1; keep at least one bit for degenerate widths.
   function automatic int cnt_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int CNT_W = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply (LSB first) or restoring divide (MSB first).
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             op_i,
   input  logic [WIDTH-1:0] hi_i,
   input  logic [WIDTH-1:0] lo_i,
   input  logic [WIDTH-1:0] opnd_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shl;
   logic [WIDTH-1:0] diff;
   logic             ge;

   assign sum  = {1'b0, hi_i} + {1'b0, opnd_i};
   assign shl  = {hi_i, lo_i[WIDTH-1]};
   assign ge   = (shl >= {1'b0, opnd_i});
   // When ge holds the true difference is below the divisor, so WIDTH bits suffice.
   assign diff = shl[WIDTH-1:0] - opnd_i;

   always_comb begin
      hi_o = hi_i;
      lo_o = lo_i;
      if (op_i == OP_MUL) begin
         if (lo_i[0]) begin
            hi_o = sum[WIDTH:1];
            lo_o = {sum[0], lo_i[WIDTH-1:1]};
         end else begin
            hi_o = {1'b0, hi_i[WIDTH-1:1]};
            lo_o = {hi_i[0], lo_i[WIDTH-1:1]};
         end
      end else begin
         if (ge) begin
            hi_o = diff;
            lo_o = {lo_i[WIDTH-2:0], 1'b1};
         end else begin
            hi_o = shl[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential unsigned multiply/divide, one bit per clock; results match the single-cycle ALU.
//
// state  | meaning
// S_IDLE | waiting for start; outputs hold last result
// S_CALC | iterating (WIDTH edges), or one edge to flag divide-by-zero
// S_DONE | done pulse, result/overflow valid
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] overflow,
   output logic             div_by_zero
);

   localparam int CW = cnt_w(WIDTH);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             op_q, op_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] ovf_q, ovf_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] step_hi, step_lo;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .op_i   (op_q),
      .hi_i   (hi_q),
      .lo_i   (lo_q),
      .opnd_i (opnd_q),
      .hi_o   (step_hi),
      .lo_o   (step_lo)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= OP_MUL;
         opnd_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         res_q   <= '0;
         ovf_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         opnd_q  <= opnd_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
         dz_q    <= dz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      opnd_d  = opnd_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      res_d   = res_q;
      ovf_d   = ovf_q;
      dz_d    = dz_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d  = op;
               hi_d  = '0;
               cnt_d = CW'(WIDTH - 1);
               dz_d  = 1'b0;
               // lo carries the multiplier (MUL) or the dividend (DIV); opnd is the other one.
               if (op == OP_MUL) begin
                  opnd_d = A;
                  lo_d   = B;
               end else begin
                  opnd_d = B;
                  lo_d   = A;
               end
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            if ((op_q == OP_DIV) && (opnd_q == '0)) begin
               res_d   = '1;
               ovf_d   = lo_q;
               dz_d    = 1'b1;
               state_d = S_DONE;
            end else begin
               hi_d  = step_hi;
               lo_d  = step_lo;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == '0) begin
                  res_d   = step_lo;
                  ovf_d   = step_hi;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign busy        = (state_q == S_CALC) || (state_q == S_DONE);
   assign done        = (state_q == S_DONE);
   assign result      = res_q;
   assign overflow    = ovf_q;
   assign div_by_zero = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq: stimulus pushes expected results, a monitor checks each done pulse.
module tb_muldiv_seq;
   import muldiv_pkg::*;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         op = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] result, overflow;

   muldiv_seq #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .A           (A),
      .B           (B),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .overflow    (overflow),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] res;
      logic [W-1:0] ovf;
      logic         dz;
      int           acc;
      int           lat;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   busy_run = 0;
   logic done_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst) begin
         busy_run  = 0;
         done_prev = 1'b0;
      end else begin
         busy_run = busy ? busy_run + 1 : 0;
         if (done) begin
            chk("done_single_pulse", {31'd0, done_prev}, 32'd0);
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("result", {16'd0, result}, {16'd0, e.res});
               chk("overflow", {16'd0, overflow}, {16'd0, e.ovf});
               chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
               chk("latency", cyc - e.acc, e.lat);
               chk("busy_cycles", busy_run, e.lat + 1);
            end
         end
         done_prev = done;
      end
   end

   task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit push, input logic [W-1:0] er, input logic [W-1:0] eo,
                        input logic ed, input int lat);
      @(negedge clk);
      op    = o;
      A     = a;
      B     = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      A     = ~a;
      B     = ~b;
      op    = ~o;
      if (push) sb.push_back('{er, eo, ed, cyc, lat});
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy || sb.size() != 0) && n < 200);
      if (n >= 200) chk("wait_idle_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_result", {16'd0, result}, 32'd0);
      chk("rst_overflow", {16'd0, overflow}, 32'd0);
      chk("rst_dz", {31'd0, div_by_zero}, 32'd0);
      rst = 1'b0;

      issue(OP_MUL, 16'h012C, 16'h012C, 1, 16'h5F90, 16'h0001, 1'b0, 16); wait_idle();
      issue(OP_MUL, 16'hFFFF, 16'hFFFF, 1, 16'h0001, 16'hFFFE, 1'b0, 16); wait_idle();
      issue(OP_MUL, 16'h8000, 16'h0002, 1, 16'h0000, 16'h0001, 1'b0, 16); wait_idle();
      issue(OP_DIV, 16'h03E8, 16'h0007, 1, 16'h008E, 16'h0006, 1'b0, 16); wait_idle();
      issue(OP_DIV, 16'h0005, 16'h0009, 1, 16'h0000, 16'h0005, 1'b0, 16); wait_idle();
      issue(OP_DIV, 16'hFFFF, 16'h0001, 1, 16'hFFFF, 16'h0000, 1'b0, 16); wait_idle();

      issue(OP_DIV, 16'h1234, 16'h0000, 1, 16'hFFFF, 16'h1234, 1'b1, 1); wait_idle();
      repeat (3) @(negedge clk);
      chk("dz_hold_result", {16'd0, result}, 32'h0000FFFF);
      chk("dz_hold_flag", {31'd0, div_by_zero}, 32'd1);

      issue(OP_MUL, 16'h0002, 16'h0003, 1, 16'h0006, 16'h0000, 1'b0, 16);
      chk("dz_cleared_at_start", {31'd0, div_by_zero}, 32'd0);
      wait_idle();

      // A second start mid-calculation must be dropped, not queued.
      issue(OP_MUL, 16'h00FF, 16'h0101, 1, 16'hFFFF, 16'h0000, 1'b0, 16);
      repeat (4) @(negedge clk);
      op = OP_DIV; A = 16'h0007; B = 16'h0000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat (5) @(negedge clk);
      chk("ignored_hold_result", {16'd0, result}, 32'h0000FFFF);
      chk("ignored_hold_overflow", {16'd0, overflow}, 32'd0);
      chk("ignored_hold_dz", {31'd0, div_by_zero}, 32'd0);
      chk("ignored_busy", {31'd0, busy}, 32'd0);

      issue(OP_DIV, 16'hABCD, 16'h0012, 0, 16'h0, 16'h0, 1'b0, 16);
      repeat (7) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_result", {16'd0, result}, 32'd0);
      chk("abort_overflow", {16'd0, overflow}, 32'd0);
      chk("abort_dz", {31'd0, div_by_zero}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("abort_no_done", {31'd0, busy}, 32'd0);

      issue(OP_DIV, 16'hABCD, 16'h0012, 1, 16'h098B, 16'h0007, 1'b0, 16); wait_idle();

      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule
